question_recorder: RTL and testbench
====================================

Name: question_recorder

Overview:
- Quiz-game answer recorder: the writer side of the per-player answer lists consumed by the inspect view.
- Active while view == 3 (answering view). The host opens a question, the first player to buzz is locked, and the host judges the answer correct or wrong. If the host does not judge in time, the answer times out.
- Writes one 2-bit result code per question into the answering player's 18-bit list and advances play_count (max 9 questions).

Parameters:
- MAX_Q, 9, number of question slots per list (list width = 2*MAX_Q).
- ANSWER_TICKS, 500_000_000, clk cycles allowed in JUDGE before timeout (5 s at 100 MHz).
- BUZZ_TICKS, 20_000_000, clk cycles buzzer stays high after a buzz lock.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- view  input  3  current UI view; block active only when view == 3
- bt_edge  input  5  one-cycle button edge pulses: [0] correct, [1] wrong, [2] start/skip question, [3] clear all, [4] unused
- player_buzz  input  4  one-cycle buzz pulses, bit i = player i+1
- play_count  output  4  number of committed questions, 0..MAX_Q
- player1_list  output  18  player 1 codes; question k (1-based) at bits [2k-1:2k-2]
- player2_list  output  18  same, player 2
- player3_list  output  18  same, player 3
- player4_list  output  18  same, player 4
- answerer  output  3  locked player 1..4; 0 = none
- led  output  24  [3:0] one-hot of answerer, [7:4] = state one-hot (IDLE, WAIT_BUZZ, JUDGE, DONE), rest 0
- buzzer  output  1  buzz-lock indication pulse

Behaviour:
- Codes: 00 = no answer, 01 = correct, 10 = wrong, 11 = timed out. At most one list is nonzero per slot.
- Reset (async): state=IDLE, play_count=0, all lists=0, answerer=0, timers=0, buzzer=0, led=0.
- Leaving view 3 (view != 3): state→IDLE, answerer=0, timer cleared, buzzer=0 next cycle. Lists and play_count are retained. An in-flight question is abandoned with no write.
- All inputs are ignored when view != 3.
- clear (bt_edge[3]) in any state while view==3:
  - lists=0, play_count=0, answerer=0, state=IDLE next cycle.
  - clear has priority over all other inputs in the same cycle.
- IDLE:
  - start with play_count<MAX_Q → WAIT_BUZZ next cycle.
  - If play_count==MAX_Q, state is DONE instead.
  - Buzzes and judge buttons are ignored.
- WAIT_BUZZ:
  - Any buzz bit set → lock the lowest-index set player (player1 highest priority) into answerer, load timer=ANSWER_TICKS-1 and buzzer timer=BUZZ_TICKS, → JUDGE.
  - start here = skip: commit slot as 00 for all players, play_count+1, → IDLE (or DONE if the new count == MAX_Q).
  - If a buzz and a start arrive in the same cycle, the buzz wins.
- JUDGE:
  - Further buzzes are ignored.
  - correct alone → write 01 into answerer's slot play_count; wrong alone → write 10.
  - correct and wrong in the same cycle → ignored, timer keeps running.
  - Timer decrements each cycle. If it is 0 with no judge press, write 11.
  - A judge press in the expiry cycle wins over the timeout.
  - Each write: slot index = current play_count (0-based); play_count+1 in the same cycle; answerer=0; → IDLE, or → DONE if the new count == MAX_Q.
  - Commit latency: list and play_count visible one cycle after the press.
- DONE: only clear or rst leave it. All other inputs are ignored.
- buzzer:
  - High from the cycle after the lock for BUZZ_TICKS cycles, independent of state changes, except that it is cleared by view change, clear, or rst.
  - A new lock reloads the buzzer timer.
- play_count never exceeds MAX_Q. Slot writes never touch other slots or other players.

Test Plan:
- Use ANSWER_TICKS=20 and BUZZ_TICKS=5 in all scenarios.
- rst mid-JUDGE (answerer=2) → all outputs 0 asynchronously; state IDLE after release.
- view=3, start, player_buzz=4'b0110, correct → answerer=2 for the JUDGE period; player2_list=18'h00001; play_count=1; buzzer high exactly 5 cycles.
- Continue: start, buzz player4, wait 20 cycles with no press → player4_list[3:2]=2'b11; play_count=2. Next question: start, buzz player1, correct+wrong together (ignored), then wrong → player1_list[5:4]=2'b10.
- Skip: start, then start again → all lists' slot 4 = 00; play_count=4. Switching view to 4 during WAIT_BUZZ → IDLE, lists unchanged.
- Fill 9 questions → play_count=9 and state DONE (led[7]=1); further start/buzz/correct cause no change. clear → lists=0, play_count=0, state IDLE.
- Buzz and start in the same WAIT_BUZZ cycle → lock taken (JUDGE), no skip; judge press in the timer-expiry cycle → writes 01/10, not 11.

Source files
------------

// File: rtl/question_recorder.sv
// question_recorder
// Quiz-game answer recorder. While the answering view (view == 3) is shown,
// the host opens a question, the first buzzing player is locked in, and the
// host judges the answer; an unjudged answer times out. One 2-bit result code
// per question is written into the answering player's list.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   view                current UI view; block active only when view == 3
//   bt_edge             button pulses: [0] correct, [1] wrong, [2] start/skip,
//                       [3] clear all, [4] unused
//   player_buzz         buzz pulses, bit i = player i+1
//   play_count          committed questions, 0..MAX_Q
//   player1..4_list     result codes, question k at bits [2k-1:2k-2]
//                       (00 none, 01 correct, 10 wrong, 11 timed out)
//   answerer            locked player 1..4, 0 = none
//   led                 [3:0] answerer one-hot, [7:4] state one-hot
//                       (IDLE, WAIT_BUZZ, JUDGE, DONE), rest 0
//   buzzer              high for BUZZ_TICKS cycles after a buzz lock
module question_recorder #(
    parameter int unsigned MAX_Q        = 9,
    parameter int unsigned ANSWER_TICKS = 500_000_000,
    parameter int unsigned BUZZ_TICKS   = 20_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           view,
    input  logic [4:0]           bt_edge,
    input  logic [3:0]           player_buzz,
    output logic [3:0]           play_count,
    output logic [2*MAX_Q-1:0]   player1_list,
    output logic [2*MAX_Q-1:0]   player2_list,
    output logic [2*MAX_Q-1:0]   player3_list,
    output logic [2*MAX_Q-1:0]   player4_list,
    output logic [2:0]           answerer,
    output logic [23:0]          led,
    output logic                 buzzer
);

    localparam logic [3:0]  MAX_Q_C   = 4'(MAX_Q);
    localparam logic [31:0] ANS_LOAD  = 32'(ANSWER_TICKS - 1);
    localparam logic [31:0] BUZZ_LOAD = 32'(BUZZ_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_JUDGE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    count_q, count_d;
    logic [3:0][2*MAX_Q-1:0]       lists_q, lists_d;
    logic [2:0]                    answerer_q, answerer_d;
    logic [31:0]                   timer_q, timer_d;
    logic [31:0]                   bcnt_q, bcnt_d;
    logic                          buzzer_q, buzzer_d;
    logic [23:0]                   led_q, led_d;

    logic                          active_s;
    logic                          commit_s;
    logic                          skip_s;
    logic [1:0]                    code_s;
    logic [4:0]                    slot_s;
    logic [1:0]                    ans_idx_s;
    logic                          unused_s;

    // Lowest-index buzzing player wins the lock.
    function automatic logic [2:0] first_player(input logic [3:0] b);
        logic [2:0] r;
        if (b[0]) begin
            r = 3'd1;
        end else if (b[1]) begin
            r = 3'd2;
        end else if (b[2]) begin
            r = 3'd3;
        end else if (b[3]) begin
            r = 3'd4;
        end else begin
            r = 3'd0;
        end
        return r;
    endfunction

    function automatic logic [3:0] state_led(input state_t s);
        logic [3:0] r;
        case (s)
            S_IDLE:  r = 4'b0001;
            S_WAIT:  r = 4'b0010;
            S_JUDGE: r = 4'b0100;
            S_DONE:  r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ans_led(input logic [2:0] a);
        logic [3:0] r;
        case (a)
            3'd1:    r = 4'b0001;
            3'd2:    r = 4'b0010;
            3'd3:    r = 4'b0100;
            3'd4:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    assign active_s  = (view == 3'd3);
    assign slot_s    = {count_q, 1'b0};
    // Player 1..4 maps to list 0..3; player 4 (3'b100) wraps 00-1 to 11.
    assign ans_idx_s = answerer_q[1:0] - 2'd1;
    assign unused_s  = bt_edge[4];

    // Next-state, slot write and timer logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        lists_d    = lists_q;
        answerer_d = answerer_q;
        timer_d    = timer_q;
        commit_s   = 1'b0;
        skip_s     = 1'b0;
        code_s     = 2'b00;
        // The buzzer runs down on its own, regardless of state changes.
        bcnt_d     = (bcnt_q != 32'd0) ? (bcnt_q - 32'd1) : 32'd0;

        if (!active_s) begin
            state_d    = S_IDLE;
            answerer_d = 3'd0;
            timer_d    = 32'd0;
            bcnt_d     = 32'd0;
        end else if (bt_edge[3]) begin
            state_d    = S_IDLE;
            count_d    = 4'd0;
            lists_d    = '0;
            answerer_d = 3'd0;
            timer_d    = 32'd0;
            bcnt_d     = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bt_edge[2]) begin
                        state_d = (count_q < MAX_Q_C) ? S_WAIT : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    // A buzz outranks a simultaneous skip.
                    if (player_buzz != 4'd0) begin
                        answerer_d = first_player(player_buzz);
                        timer_d    = ANS_LOAD;
                        bcnt_d     = BUZZ_LOAD;
                        state_d    = S_JUDGE;
                    end else if (bt_edge[2]) begin
                        commit_s = 1'b1;
                        skip_s   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_JUDGE: begin
                    // Correct+wrong together is ambiguous and ignored; any
                    // valid press outranks the timeout in the expiry cycle.
                    if (bt_edge[0] && !bt_edge[1]) begin
                        commit_s = 1'b1;
                        code_s   = 2'b01;
                    end else if (bt_edge[1] && !bt_edge[0]) begin
                        commit_s = 1'b1;
                        code_s   = 2'b10;
                    end else if (timer_q == 32'd0) begin
                        commit_s = 1'b1;
                        code_s   = 2'b11;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (commit_s) begin
                if (skip_s) begin
                    for (int p = 0; p < 4; p++) begin
                        lists_d[p][slot_s +: 2] = 2'b00;
                    end
                end else begin
                    lists_d[ans_idx_s][slot_s +: 2] = code_s;
                end
                count_d    = count_q + 4'd1;
                answerer_d = 3'd0;
                timer_d    = 32'd0;
                state_d    = (count_d == MAX_Q_C) ? S_DONE : S_IDLE;
            end else begin
                count_d = count_q;
            end
        end

        buzzer_d = (bcnt_d != 32'd0);
        led_d    = {16'd0, state_led(state_d), ans_led(answerer_d)};
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            lists_q    <= '0;
            answerer_q <= 3'd0;
            timer_q    <= 32'd0;
            bcnt_q     <= 32'd0;
            buzzer_q   <= 1'b0;
            led_q      <= 24'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            lists_q    <= lists_d;
            answerer_q <= answerer_d;
            timer_q    <= timer_d;
            bcnt_q     <= bcnt_d;
            buzzer_q   <= buzzer_d;
            led_q      <= led_d;
        end
    end

    assign play_count   = count_q;
    assign player1_list = lists_q[0];
    assign player2_list = lists_q[1];
    assign player3_list = lists_q[2];
    assign player4_list = lists_q[3];
    assign answerer     = answerer_q;
    assign led          = led_q;
    assign buzzer       = buzzer_q;

endmodule

// File: tb/tb_question_recorder.sv
module tb_question_recorder;

    localparam int AT = 20;
    localparam int BT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  view = 3'd0;
    logic [4:0]  bt_edge = 5'd0;
    logic [3:0]  player_buzz = 4'd0;
    logic [3:0]  play_count;
    logic [17:0] player1_list, player2_list, player3_list, player4_list;
    logic [2:0]  answerer;
    logic [23:0] led;
    logic        buzzer;

    int n_checks = 0;
    int n_fail   = 0;

    question_recorder #(.MAX_Q(9), .ANSWER_TICKS(AT), .BUZZ_TICKS(BT)) dut (
        .clk(clk), .rst(rst), .view(view), .bt_edge(bt_edge),
        .player_buzz(player_buzz), .play_count(play_count),
        .player1_list(player1_list), .player2_list(player2_list),
        .player3_list(player3_list), .player4_list(player4_list),
        .answerer(answerer), .led(led), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE = 0, M_WAIT = 1, M_JUDGE = 2, M_DONE = 3} mphase_t;
    mphase_t m_phase;
    int      m_codes[4][9];
    int      m_count, m_ans, m_jleft, m_bleft;
    bit      m_led_zero;

    task automatic model_reset();
        m_phase = M_IDLE;
        foreach (m_codes[p, k]) m_codes[p][k] = 0;
        m_count = 0; m_ans = 0; m_jleft = 0; m_bleft = 0;
        m_led_zero = 1'b1;
    endtask

    task automatic record(input int code);
        if (code != 0) m_codes[m_ans-1][m_count] = code;
        m_count++;
        m_ans = 0;
        m_phase = (m_count == 9) ? M_DONE : M_IDLE;
    endtask

    task automatic model_step(input logic [2:0] v, input logic [4:0] bt, input logic [3:0] bz);
        m_led_zero = 1'b0;
        if (v != 3'd3) begin
            m_phase = M_IDLE; m_ans = 0; m_jleft = 0; m_bleft = 0;
            return;
        end
        if (m_bleft > 0) m_bleft--;
        if (bt[3]) begin
            foreach (m_codes[p, k]) m_codes[p][k] = 0;
            m_count = 0; m_ans = 0; m_phase = M_IDLE; m_bleft = 0; m_jleft = 0;
            return;
        end
        case (m_phase)
            M_IDLE: if (bt[2]) m_phase = (m_count < 9) ? M_WAIT : M_DONE;
            M_WAIT: begin
                if (bz != 4'd0) begin
                    for (int i = 3; i >= 0; i--) if (bz[i]) m_ans = i + 1;
                    m_jleft = AT; m_bleft = BT; m_phase = M_JUDGE;
                end else if (bt[2]) begin
                    record(0);
                end
            end
            M_JUDGE: begin
                if (bt[0] && !bt[1])      record(1);
                else if (bt[1] && !bt[0]) record(2);
                else if (m_jleft == 1)    record(3);
                else                      m_jleft--;
            end
            default: ;
        endcase
    endtask

    function automatic logic [17:0] pack(input int p);
        logic [17:0] v = 18'd0;
        for (int k = 0; k < 9; k++) v[2*k +: 2] = 2'(m_codes[p][k]);
        return v;
    endfunction

    function automatic logic [23:0] exp_led();
        logic [23:0] v = 24'd0;
        if (!m_led_zero) begin
            v[4 + int'(m_phase)] = 1'b1;
            if (m_ans != 0) v[m_ans-1] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("play_count", 32'(play_count), 32'(m_count));
        cmp("player1_list", 32'(player1_list), 32'(pack(0)));
        cmp("player2_list", 32'(player2_list), 32'(pack(1)));
        cmp("player3_list", 32'(player3_list), 32'(pack(2)));
        cmp("player4_list", 32'(player4_list), 32'(pack(3)));
        cmp("answerer", 32'(answerer), 32'(m_ans));
        cmp("led", 32'(led), 32'(exp_led()));
        cmp("buzzer", 32'(buzzer), 32'(m_bleft > 0));
    endtask

    task automatic cyc(input logic [2:0] v, input logic [4:0] bt, input logic [3:0] bz);
        view = v; bt_edge = bt; player_buzz = bz;
        @(posedge clk);
        model_step(v, bt, bz);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'd3, 5'd0, 4'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  v;
        logic [4:0]  bt;
        logic [3:0]  bz;
        logic [3:0]  cnt;
        logic [2:0]  ans;
        logic        bzr;
        logic [3:0]  st;
        logic [17:0] p2;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{3'd3, 5'b00100, 4'b0000, 4'd0, 3'd0, 1'b0, 4'b0010, 18'h0};
        tbl[1]  = '{3'd3, 5'b00000, 4'b0110, 4'd0, 3'd2, 1'b1, 4'b0100, 18'h0};
        tbl[2]  = '{3'd3, 5'b00000, 4'b0000, 4'd0, 3'd2, 1'b1, 4'b0100, 18'h0};
        tbl[3]  = '{3'd3, 5'b00000, 4'b0001, 4'd0, 3'd2, 1'b1, 4'b0100, 18'h0};
        tbl[4]  = '{3'd3, 5'b00000, 4'b0000, 4'd0, 3'd2, 1'b1, 4'b0100, 18'h0};
        tbl[5]  = '{3'd3, 5'b00000, 4'b0000, 4'd0, 3'd2, 1'b1, 4'b0100, 18'h0};
        tbl[6]  = '{3'd3, 5'b00000, 4'b0000, 4'd0, 3'd2, 1'b0, 4'b0100, 18'h0};
        tbl[7]  = '{3'd3, 5'b00001, 4'b0000, 4'd1, 3'd0, 1'b0, 4'b0001, 18'h1};
        tbl[8]  = '{3'd3, 5'b00000, 4'b1000, 4'd1, 3'd0, 1'b0, 4'b0001, 18'h1};
        tbl[9]  = '{3'd3, 5'b00011, 4'b0000, 4'd1, 3'd0, 1'b0, 4'b0001, 18'h1};
        tbl[10] = '{3'd4, 5'b00100, 4'b0000, 4'd1, 3'd0, 1'b0, 4'b0001, 18'h1};
        tbl[11] = '{3'd3, 5'b00100, 4'b0000, 4'd1, 3'd0, 1'b0, 4'b0010, 18'h1};
        tbl[12] = '{3'd5, 5'b00000, 4'b0010, 4'd1, 3'd0, 1'b0, 4'b0001, 18'h1};
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, guard;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();                      // reset state: all zero
        @(negedge clk);
        rst = 1'b0;

        // Bring a question into JUDGE with player 2, then reset mid-cycle.
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'd0, 4'b0010);
        idle(2);
        cmp("pre_rst_answerer", 32'(answerer), 32'd2);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_model();                      // async clear, before any edge
        @(negedge clk);
        rst = 1'b0;
        cyc(3'd3, 5'd0, 4'd0);
        cmp("post_rst_idle", 32'(led[7:4]), 32'h1);

        // Table-driven first question.
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].bt, tbl[i].bz);
            cmp($sformatf("tbl%0d_cnt", i), 32'(play_count), 32'(tbl[i].cnt));
            cmp($sformatf("tbl%0d_ans", i), 32'(answerer), 32'(tbl[i].ans));
            cmp($sformatf("tbl%0d_buzzer", i), 32'(buzzer), 32'(tbl[i].bzr));
            cmp($sformatf("tbl%0d_state", i), 32'(led[7:4]), 32'(tbl[i].st));
            cmp($sformatf("tbl%0d_p2", i), 32'(player2_list), 32'(tbl[i].p2));
        end

        // Timeout for player 4 on question 2.
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'd0, 4'b1000);
        idle(AT);
        cmp("p4_timeout", 32'(player4_list[3:2]), 32'h3);
        cmp("count_2", 32'(play_count), 32'd2);

        // Ambiguous press ignored, then wrong for player 1.
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'd0, 4'b0001);
        cyc(3'd3, 5'b00011, 4'd0);
        cmp("both_ignored", 32'(answerer), 32'd1);
        cyc(3'd3, 5'b00010, 4'd0);
        cmp("p1_wrong", 32'(player1_list[5:4]), 32'h2);

        // Skip question 4.
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'b00100, 4'd0);
        cmp("skip_count", 32'(play_count), 32'd4);
        cmp("skip_slot", 32'({player1_list[7:6], player2_list[7:6],
                               player3_list[7:6], player4_list[7:6]}), 32'd0);

        // View change during WAIT_BUZZ.
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd4, 5'd0, 4'd0);
        cmp("view_idle", 32'(led[7:4]), 32'h1);
        cmp("view_keep_p4", 32'(player4_list), 32'(18'h0000C));

        // Fill the remaining questions with random outcomes.
        guard = 0;
        while (m_count < 9 && guard < 40) begin
            guard++;
            cyc(3'd3, 5'b00100, 4'd0);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                cyc(3'd3, 5'b00100, 4'd0);
            end else begin
                cyc(3'd3, 5'd0, 4'($urandom_range(1, 15)));
                if (r == 3) begin
                    idle(AT);
                end else begin
                    idle($urandom_range(0, 5));
                    cyc(3'd3, (r == 1) ? 5'b00001 : 5'b00010, 4'd0);
                end
            end
        end
        cmp("full_count", 32'(play_count), 32'd9);
        cmp("done_led", 32'(led[7]), 32'd1);
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'd0, 4'b0001);
        cyc(3'd3, 5'b00001, 4'd0);
        cmp("done_hold", 32'(play_count), 32'd9);
        cmp("done_state", 32'(led[7:4]), 32'h8);
        cyc(3'd3, 5'b01111, 4'b1111);      // clear outranks everything
        cmp("clear_count", 32'(play_count), 32'd0);
        cmp("clear_lists", 32'(player1_list | player2_list | player3_list | player4_list), 32'd0);
        cmp("clear_state", 32'(led[7:4]), 32'h1);

        // Buzz and start together: lock wins. Press in the expiry cycle.
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'b00100, 4'b0100);
        cmp("buzz_over_skip_ans", 32'(answerer), 32'd3);
        cmp("buzz_over_skip_cnt", 32'(play_count), 32'd0);
        idle(AT - 1);
        cyc(3'd3, 5'b00010, 4'd0);
        cmp("expiry_wrong", 32'(player3_list[1:0]), 32'h2);
        cyc(3'd3, 5'b00100, 4'd0);
        cyc(3'd3, 5'd0, 4'b0001);
        idle(AT - 1);
        cyc(3'd3, 5'b00001, 4'd0);
        cmp("expiry_correct", 32'(player1_list[3:2]), 32'h1);
        cmp("expiry_count", 32'(play_count), 32'd2);

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] v;
            logic [4:0] bt;
            logic [3:0] bz;
            v = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            bt[0] = ($urandom_range(0, 7) == 0);
            bt[1] = ($urandom_range(0, 7) == 0);
            bt[2] = ($urandom_range(0, 4) == 0);
            bt[3] = ($urandom_range(0, 149) == 0);
            bt[4] = 1'($urandom_range(0, 1));
            bz = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            cyc(v, bt, bz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
